// File: rtl/acc_sum64_if.sv
`default_nettype none
// ============================================================================
// Module   : acc_sum64_if
// Brief    : Command, input-stream and result bundle for acc_sum64.
// Revision : 1.0
// ============================================================================
interface acc_sum64_if #(
    parameter int LEN_W = 8
) ();
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic [31:0]      in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      sum;
    logic             busy;
    logic             ovf;

    modport slave (
        input  start, len, in_valid, in_data, out_ready,
        output in_ready, out_valid, sum, busy, ovf
    );

    modport master (
        output start, len, in_valid, in_data, out_ready,
        input  in_ready, out_valid, sum, busy, ovf
    );
endinterface
`default_nettype wire

// File: rtl/acc_sum64.sv
`default_nettype none
// ============================================================================
// Module   : acc_sum64
// Brief    : Burst-framed streaming 64-bit accumulator; ACC_SAT_EN selects
//            saturation of the sum on high-word overflow instead of wrapping.
// Revision : 1.0
// ============================================================================
module acc_sum64 #(
    parameter int LEN_W = 8
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    acc_sum64_if.slave   bus
);
    localparam logic [1:0] c_s_idle  = 2'd0;
    localparam logic [1:0] c_s_accum = 2'd1;
    localparam logic [1:0] c_s_done  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [31:0]      r_lo;
    logic [31:0]      r_hi;
    logic [LEN_W-1:0] r_cnt;
    logic             r_ovf;

    logic             w_beat;
    logic             w_last;
    logic             w_c31;
    logic             w_hi_c;
    logic [31:0]      w_lo_sum;
    logic [31:0]      w_hi_sum;

    assign w_beat = (r_state == c_s_accum) && bus.in_valid;
    assign w_last = w_beat && (r_cnt == LEN_W'(1));

    // The low-word carry feeds the high word in the same cycle.
    assign {w_c31, w_lo_sum}  = {1'b0, r_lo} + {1'b0, bus.in_data};
    assign {w_hi_c, w_hi_sum} = {1'b0, r_hi} + {32'd0, w_c31};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_s_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_s_idle: begin
                if (bus.start) begin
                    w_state_nxt = (bus.len == '0) ? c_s_done : c_s_accum;
                end
            end
            c_s_accum: begin
                if (w_last) begin
                    w_state_nxt = c_s_done;
                end
            end
            c_s_done: begin
                if (bus.out_ready) begin
                    w_state_nxt = c_s_idle;
                end
            end
            default: w_state_nxt = c_s_idle;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        case (r_state)
            c_s_accum: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b1;
            end
            c_s_done: begin
                bus.out_valid = 1'b1;
                bus.busy      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lo  <= '0;
            r_hi  <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if ((r_state == c_s_idle) && bus.start) begin
            r_lo  <= '0;
            r_hi  <= '0;
            r_cnt <= bus.len;
            r_ovf <= 1'b0;
        end else if (w_beat) begin
            r_cnt <= r_cnt - LEN_W'(1);
            if (w_hi_c) begin
                r_ovf <= 1'b1;
            end
`ifdef ACC_SAT_EN
            // Once overflowed, the sum stays pinned while remaining beats drain.
            if (w_hi_c || r_ovf) begin
                r_lo <= '1;
                r_hi <= '1;
            end else begin
                r_lo <= w_lo_sum;
                r_hi <= w_hi_sum;
            end
`else
            r_lo <= w_lo_sum;
            r_hi <= w_hi_sum;
`endif
        end
    end

    assign bus.sum = {r_hi, r_lo};
    assign bus.ovf = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_acc_sum64.sv
`default_nettype none
// ============================================================================
// Module   : tb_acc_sum64
// Brief    : Directed scoreboard bench for acc_sum64 (ACC_SAT_EN aware).
// Revision : 1.0
// ============================================================================
module tb_acc_sum64;
    typedef struct {
        logic [63:0] sum;
        logic        ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    exp_t sb[$];

    acc_sum64_if #(.LEN_W(8)) bus ();

    acc_sum64 #(.LEN_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Results are popped one cycle-phase after the driver's negedge updates.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_sum", bus.sum, e.sum);
                    chk("sb_ovf", {63'd0, bus.ovf}, {63'd0, e.ovf});
                end
            end
        end
    end

    task automatic push(input logic [63:0] s, input logic o);
        exp_t e;
        e.sum = s;
        e.ovf = o;
        sb.push_back(e);
    endtask

    task automatic start_burst(input logic [7:0] l);
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = l;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic send(input logic [31:0] w, input bit bubble);
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (bubble) @(negedge clk);
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        #12;
        chk("reset_outputs", {bus.sum[62:0], bus.busy, bus.in_ready, bus.out_valid, bus.ovf},
            67'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Simple burst with first-ready and result-latency timing.
        push(64'd6, 1'b0);
        start_burst(8'd3);
        chk("simple_in_ready", {63'd0, bus.in_ready}, 64'd1);
        send(32'd1, 0);
        send(32'd2, 0);
        chk("simple_not_done_early", {63'd0, bus.out_valid}, 64'd0);
        send(32'd3, 0);
        chk("simple_out_valid", {63'd0, bus.out_valid}, 64'd1);
        @(negedge clk);
        chk("simple_back_idle", {62'd0, bus.busy, bus.out_valid}, 64'd0);

        // Low-word carry into high word.
        push(64'h0000_0001_0000_0000, 1'b0);
        start_burst(8'd2);
        send(32'hFFFF_FFFF, 0);
        send(32'h0000_0001, 0);
        @(negedge clk);

        // Bubbles on input, back-pressure on output.
        bus.out_ready = 1'b0;
        push(64'h0000_0002_0000_0000, 1'b0);
        start_burst(8'd4);
        send(32'h8000_0000, 1);
        send(32'h8000_0000, 1);
        send(32'h8000_0000, 1);
        send(32'h8000_0000, 0);
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", {63'd0, bus.out_valid}, 64'd1);
            chk("bp_sum_held", bus.sum, 64'h0000_0002_0000_0000);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_idle_sum_kept", bus.sum, 64'h0000_0002_0000_0000);

        // Zero length.
        push(64'd0, 1'b0);
        start_burst(8'd0);
        chk("zero_len_valid", {63'd0, bus.out_valid}, 64'd1);
        @(negedge clk);

        // Start during ACCUM is ignored.
        push(64'd60, 1'b0);
        start_burst(8'd3);
        bus.start = 1'b1;
        bus.len   = 8'd9;
        @(negedge clk);
        bus.start = 1'b0;
        chk("ignored_start_cnt", {56'd0, dut.r_cnt}, 64'd3);
        send(32'd10, 0);
        send(32'd20, 0);
        send(32'd30, 0);
        @(negedge clk);

        // Long preload burst, then confirm clear on next start.
        push(64'h0000_00FE_FFFF_FF01, 1'b0);
        start_burst(8'd255);
        for (int i = 0; i < 255; i++) send(32'hFFFF_FFFF, 0);
        @(negedge clk);
        push(64'd5, 1'b0);
        start_burst(8'd1);
        chk("clear_on_start", bus.sum, 64'd0);
        send(32'd5, 0);
        @(negedge clk);

        // Forced high-word wrap.
`ifdef ACC_SAT_EN
        push(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
`else
        push(64'd0, 1'b1);
`endif
        start_burst(8'd1);
        force dut.r_hi = 32'hFFFF_FFFF;
        force dut.r_lo = 32'hFFFF_FFFF;
        #1;
        release dut.r_hi;
        release dut.r_lo;
        send(32'd1, 0);
        chk("ovf_flag", {63'd0, bus.ovf}, 64'd1);
        @(negedge clk);
        chk("ovf_sticky_idle", {63'd0, bus.ovf}, 64'd1);

        // Reset mid-burst aborts with no result.
        start_burst(8'd5);
        send(32'd100, 0);
        send(32'd200, 0);
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs", {bus.sum[62:0], bus.busy, bus.in_ready, bus.out_valid, bus.ovf},
            67'd0);
        chk("midreset_state", {62'd0, dut.r_state}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        push(64'd7, 1'b0);
        start_burst(8'd1);
        send(32'd7, 0);
        @(negedge clk);
        @(negedge clk);

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/acc_sum64.md
# acc_sum64

Streaming 64-bit accumulator that sits directly downstream of the 32-bit carry-lookahead adder. Each accepted 32-bit word is added to the low accumulator word with carry-in 0, and the adder's carry-out increments the high word. A start/length command frames each burst, and a valid/ready handshake on both the input and the result sides lets it sit between a word source and a result consumer at one word per cycle.

## Interface
- LEN_W, default 8: width of the burst length field; maximum burst is 2^LEN_W − 1 words.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a burst; sampled only in IDLE.
- len  in  LEN_W  number of words in the burst; sampled with start.
- in_valid  in  1  in_data is valid.
- in_data  in  32  word to accumulate.
- in_ready  out  1  block accepts in_data this cycle.
- out_valid  out  1  sum is final and stable.
- out_ready  in  1  consumer takes the result.
- sum  out  64  accumulator {hi, lo}.
- busy  out  1  high in ACCUM and DONE.
- ovf  out  1  sticky high-word overflow flag (see Configuration).

## Operation
- FSM states:
  - IDLE: in_ready=0, out_valid=0, busy=0.
  - ACCUM: in_ready=1, busy=1.
  - DONE: out_valid=1, busy=1, in_ready=0.
- IDLE with start=1:
  - Clear lo, hi and ovf, and load cnt←len.
  - If len≠0, go to ACCUM. If len=0, go to DONE with sum=0.
- ACCUM, per beat (in_valid & in_ready):
  - {C31, lo'} = lo + in_data, with carry-in 0.
  - hi' = hi + C31.
  - cnt decrements by 1.
  - If cnt=1 at that beat, go to DONE.
  - A cycle with in_valid=0 holds all state.
- DONE: sum is held constant. out_valid & out_ready returns the FSM to IDLE. sum keeps its value in IDLE until the next start.
- Commands outside IDLE: start and len are ignored in ACCUM and DONE, with no queuing.
- Width rules:
  - All arithmetic is modulo 2^32 per word.
  - The high-word increment is the carry-out only; there is no 64-bit carry-in.
  - A carry out of hi is the overflow event.
- Reset values: all outputs 0, state IDLE, lo/hi/cnt/ovf 0. Asserting rst_n mid-burst aborts the burst immediately, with no result and no handshake completion.

## Timing
- Start to first in_ready: start sampled at edge N, in_ready high from cycle N+1.
- Throughput: one word per cycle when in_valid is held high.
- Latency: the last-beat handshake at edge M gives out_valid high and final sum valid from cycle M+1.
- Burst duration: with continuous input and out_ready=1, IDLE to IDLE takes len+2 cycles.
- len=0: out_valid high one cycle after start.
- Carry path: C31 feeds the hi update in the same cycle as lo; both registers update on the same edge.
- out_ready high while not in DONE has no effect.

## Configuration
- ACC_SAT_EN defined:
  - When a beat would overflow hi (hi=0xFFFFFFFF and C31=1), sum sticks at 0xFFFF_FFFF_FFFF_FFFF for the rest of the burst.
  - ovf goes high and stays high until the next start.
  - Later beats are still consumed, and cnt still counts.
- ACC_SAT_EN undefined:
  - sum wraps modulo 2^64.
  - ovf still goes high and stays sticky on the hi carry-out event, until the next start.

## Test plan
- Simple burst: start, len=3, words 1, 2, 3 with in_valid held high -> out_valid 4 cycles after start, sum=6, ovf=0; out_ready=1 returns to IDLE next cycle.
- Low-word carry: len=2, words 0xFFFFFFFF, 0x00000001 -> sum=0x0000_0001_0000_0000.
- Bubbles and back-pressure: len=4 of 0x80000000, in_valid toggling 1/0, out_ready held 0 for 3 cycles in DONE -> sum=0x0000_0002_0000_0000, held stable with out_valid=1 until out_ready.
- Zero length and ignored start: len=0 -> out_valid the next cycle with sum=0; start pulsed during ACCUM is ignored and cnt is unchanged.
- Overflow: preload via a burst with len=255 words of 0xFFFFFFFF, then a second burst starting from 0 to confirm the clear. Then force hi wrap with a Verilog-forced hi=0xFFFFFFFF and lo=0xFFFFFFFF, followed by word 1 -> with ACC_SAT_EN: sum=all ones, ovf=1; without: sum=0, ovf=1.
- Reset mid-burst: rst_n low after 2 of 5 beats -> all outputs 0 and state IDLE immediately; a new start with len=1, word 7 gives sum=7.
